// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM state encoding and op-classification helpers for the
// HI/LO multiply/divide sequencer.
package muldiv_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_MULT  = 4'd0;
  localparam logic [OP_W-1:0] OP_MULTU = 4'd1;
  localparam logic [OP_W-1:0] OP_DIV   = 4'd2;
  localparam logic [OP_W-1:0] OP_DIVU  = 4'd3;
  localparam logic [OP_W-1:0] OP_MADD  = 4'd4;
  localparam logic [OP_W-1:0] OP_MSUB  = 4'd5;
  localparam logic [OP_W-1:0] OP_MTHI  = 4'd6;
  localparam logic [OP_W-1:0] OP_MTLO  = 4'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  typedef enum logic {
    STEP_MUL = 1'b0,
    STEP_DIV = 1'b1
  } step_mode_e;

  function automatic logic is_div_op(input logic [OP_W-1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [OP_W-1:0] op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  // Ops that run through RUN/FIX; MTHI/MTLO and undefined codes do not.
  function automatic logic is_iter_op(input logic [OP_W-1:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) ||
           (op == OP_DIVU) || (op == OP_MADD)  || (op == OP_MSUB);
  endfunction

endpackage

// File: rtl/hilo_muldiv_sequencer_if.sv
// Request/response bundle between the EX stage (master) and the HI/LO
// sequencer (slave).
interface hilo_muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  import muldiv_pkg::*;

  logic             Start;
  logic [OP_W-1:0]  Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Flush;
  logic             HiLoRead;
  logic             Busy;
  logic             Stall;
  logic             Done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output Start, Op, A, B, Flush, HiLoRead,
    input  Busy, Stall, Done, HI, LO
  );

  modport slave (
    input  Start, Op, A, B, Flush, HiLoRead,
    output Busy, Stall, Done, HI, LO
  );

endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply ({acc, multiplier}) or
// restoring shift-subtract for divide ({remainder, quotient}).
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] partial_i,
  input  logic [WIDTH-1:0]   operand_i,
  input  step_mode_e         mode_i,
  output logic [2*WIDTH-1:0] partial_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted_hi;
  logic [WIDTH:0] trial;

  // NOTE: every output and temporary gets a default first, so no path through
  // this block can leave a value unassigned and infer a latch.
  always_comb begin
    sum        = '0;
    shifted_hi = '0;
    trial      = '0;
    partial_o  = partial_i;
    if (mode_i == STEP_MUL) begin
      sum       = {1'b0, partial_i[2*WIDTH-1:WIDTH]} +
                  (partial_i[0] ? {1'b0, operand_i} : '0);
      partial_o = {sum, partial_i[WIDTH-1:1]};
    end else begin
      // The remainder stays below the divisor, so {rem, next bit} fits WIDTH+1.
      shifted_hi = partial_i[2*WIDTH-1:WIDTH-1];
      trial      = shifted_hi - {1'b0, operand_i};
      if (!trial[WIDTH]) begin
        partial_o = {trial[WIDTH-1:0], partial_i[WIDTH-2:0], 1'b1};
      end else begin
        partial_o = {shifted_hi[WIDTH-1:0], partial_i[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/hilo_muldiv_sequencer.sv
// HI/LO owner: sequences iterative mult/div/madd/msub and MTHI/MTLO writes.
// Optional MULDIV_EARLY_OUT_EN shortens mul-class runs once the multiplier is exhausted.
module hilo_muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic                    Clk,
  input logic                    Rst_n,
  hilo_muldiv_sequencer_if.slave bus
);

  localparam int P_W = 2 * WIDTH;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [P_W-1:0]   partial_q, partial_d;
  logic [WIDTH-1:0] operand_q, operand_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic             neg_q, neg_d;
  logic             a_neg_q, a_neg_d;
  logic             div0_q, div0_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [P_W-1:0]   step_out;
  step_mode_e       step_mode;
  logic             a_sgn, b_sgn;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [P_W-1:0]   mag, prod_signed, acc_next;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  logic             early_exit;

  assign step_mode = is_div_op(op_q) ? STEP_DIV : STEP_MUL;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .partial_i (partial_q),
    .operand_i (operand_q),
    .mode_i    (step_mode),
    .partial_o (step_out)
  );

  always_comb begin
    a_sgn = is_signed_op(bus.Op) & bus.A[WIDTH-1];
    b_sgn = is_signed_op(bus.Op) & bus.B[WIDTH-1];
    abs_a = a_sgn ? -bus.A : bus.A;
    abs_b = b_sgn ? -bus.B : bus.B;
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic [WIDTH-1:0] mplr_left;

  // After cnt_q steps the unconsumed multiplier bits sit in the low WIDTH-cnt_q
  // positions; once they are zero the product only needs re-aligning.
  always_comb begin
    mplr_left  = partial_q[WIDTH-1:0] << cnt_q;
    early_exit = !is_div_op(op_q) && (mplr_left == '0);
    mag        = partial_q >> (CNT_W'(WIDTH) - cnt_q);
  end
`else
  assign early_exit = 1'b0;
  assign mag        = partial_q;
`endif

  always_comb begin
    prod_signed = neg_q ? -mag : mag;
    acc_next    = prod_signed;
    if (op_q == OP_MADD) begin
      acc_next = {hi_q, lo_q} + prod_signed;
    end else if (op_q == OP_MSUB) begin
      acc_next = {hi_q, lo_q} - prod_signed;
    end
    quo_fix = div0_q ? '1 : (neg_q ? -partial_q[WIDTH-1:0] : partial_q[WIDTH-1:0]);
    rem_fix = a_neg_q ? -partial_q[P_W-1:WIDTH] : partial_q[P_W-1:WIDTH];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    partial_d = partial_q;
    operand_d = operand_q;
    op_d      = op_q;
    neg_d     = neg_q;
    a_neg_d   = a_neg_q;
    div0_d    = div0_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      S_IDLE: begin
        if (bus.Start && !bus.Flush) begin
          if (bus.Op == OP_MTHI) begin
            hi_d = bus.A;
          end else if (bus.Op == OP_MTLO) begin
            lo_d = bus.A;
          end else if (is_iter_op(bus.Op)) begin
            // Divide runs {0, |A|} against |B|; multiply runs {0, |B|} with |A| added.
            operand_d = is_div_op(bus.Op) ? abs_b : abs_a;
            partial_d = {{WIDTH{1'b0}}, (is_div_op(bus.Op) ? abs_a : abs_b)};
            neg_d     = a_sgn ^ b_sgn;
            a_neg_d   = a_sgn;
            div0_d    = (bus.B == '0);
            op_d      = bus.Op;
            cnt_d     = '0;
            busy_d    = 1'b1;
            state_d   = S_RUN;
          end
        end
      end

      S_RUN: begin
        if (bus.Flush) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (early_exit) begin
          state_d = S_FIX;
        end else begin
          partial_d = step_out;
          cnt_d     = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = S_FIX;
          end
        end
      end

      S_FIX: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
        if (!bus.Flush) begin
          done_d = 1'b1;
          if (is_div_op(op_q)) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            {hi_d, lo_d} = acc_next;
          end
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of order.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      partial_q <= '0;
      operand_q <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      a_neg_q   <= 1'b0;
      div0_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      partial_q <= partial_d;
      operand_q <= operand_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      a_neg_q   <= a_neg_d;
      div0_q    <= div0_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign bus.Busy  = busy_q;
  assign bus.Done  = done_q;
  assign bus.HI    = hi_q;
  assign bus.LO    = lo_q;
  assign bus.Stall = busy_q & (bus.Start | bus.HiLoRead);

endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
// Randomized and directed checks of the HI/LO sequencer against an
// arithmetic reference model of HI/LO and op latency.
module tb_hilo_muldiv_sequencer;
  import muldiv_pkg::*;

  logic clk;
  logic rst_n;

  int n_cmp;
  int n_err;

  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  hilo_muldiv_sequencer_if #(.WIDTH(32)) bus ();

  hilo_muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .Clk   (clk),
    .Rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_multi(input logic [3:0] op);
    return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MSUB};
  endfunction

  // Reference HI/LO update from plain signed/unsigned arithmetic.
  task automatic ref_exec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] acc;
    longint      sp;
    int          sa, sb;
    acc = {exp_hi, exp_lo};
    sp  = longint'($signed(a)) * longint'($signed(b));
    sa  = a;
    sb  = b;
    case (op)
      OP_MULT:  acc = sp;
      OP_MULTU: acc = {32'd0, a} * {32'd0, b};
      OP_MADD:  acc = acc + sp;
      OP_MSUB:  acc = acc - sp;
      OP_DIV: begin
        if (b == 0)                                 acc = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && sb == -1)   acc = {32'd0, 32'h8000_0000};
        else                                        acc = {32'(sa % sb), 32'(sa / sb)};
      end
      OP_DIVU: begin
        if (b == 0) acc = {a, 32'hFFFF_FFFF};
        else        acc = {a % b, a / b};
      end
      OP_MTHI: acc[63:32] = a;
      OP_MTLO: acc[31:0]  = a;
      default: ;
    endcase
    {exp_hi, exp_lo} = acc;
  endtask

  // Edges from accept to HI/LO update.
  function automatic int exp_latency(input logic [3:0] op, input logic [31:0] b);
    int k;
    k = 32;
`ifdef MULDIV_EARLY_OUT_EN
    begin
      logic [31:0] m;
      if (op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MSUB}) begin
        m = (op != OP_MULTU && b[31]) ? -b : b;
        k = 0;
        for (int i = 0; i < 32; i++) if (m[i]) k = i + 1;
      end
    end
`endif
    return (k < 32) ? k + 2 : 33;
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return $urandom_range(0, 15);
      4:       return 32'hFFFF_FFF0 | $urandom_range(0, 15);
      5:       return $urandom_range(0, 32'hFFFF);
      default: return $urandom();
    endcase
  endfunction

  // Entered on the negedge after the accept edge.
  task automatic wait_done(input int lat, input string tag);
    logic rd;
    for (int j = 0; j < lat; j++) begin
      rd = 1'($urandom_range(0, 1));
      bus.HiLoRead = rd;
      #1;
      check({tag, "_busy"},  bus.Busy,  1'b1);
      check({tag, "_done0"}, bus.Done,  1'b0);
      check({tag, "_stall"}, bus.Stall, rd);
      @(negedge clk);
    end
    bus.HiLoRead = 1'b0;
    #1;
    check({tag, "_done"},  bus.Done, 1'b1);
    check({tag, "_idle"},  bus.Busy, 1'b0);
    check({tag, "_hi"},    bus.HI,   exp_hi);
    check({tag, "_lo"},    bus.LO,   exp_lo);
    @(negedge clk);
    #1;
    check({tag, "_pulse"}, bus.Done, 1'b0);
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    int lat;
    lat       = exp_latency(op, b);
    bus.Start = 1'b1;
    bus.Op    = op;
    bus.A     = a;
    bus.B     = b;
    @(negedge clk);
    bus.Start = 1'b0;
    ref_exec(op, a, b);
    if (is_multi(op)) begin
      wait_done(lat, tag);
    end else begin
      #1;
      check({tag, "_busy"}, bus.Busy, 1'b0);
      check({tag, "_done"}, bus.Done, 1'b0);
      check({tag, "_hi"},   bus.HI,   exp_hi);
      check({tag, "_lo"},   bus.LO,   exp_lo);
    end
  endtask

  initial begin
    int lat;
    logic [3:0] op;
    n_cmp = 0;
    n_err = 0;
    exp_hi = '0;
    exp_lo = '0;
    rst_n = 1'b0;
    bus.Start = 1'b0;
    bus.Op = '0;
    bus.A = '0;
    bus.B = '0;
    bus.Flush = 1'b0;
    bus.HiLoRead = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy",  bus.Busy,  1'b0);
    check("rst_done",  bus.Done,  1'b0);
    check("rst_stall", bus.Stall, 1'b0);
    check("rst_hi",    bus.HI,    32'd0);
    check("rst_lo",    bus.LO,    32'd0);
    bus.HiLoRead = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Directed scenarios
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, "mult_neg3x7");
    check("mult_lit_hi", bus.HI, 32'hFFFF_FFFF);
    check("mult_lit_lo", bus.LO, 32'hFFFF_FFEB);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div_neg7_2");
    check("div_lit_lo", bus.LO, 32'hFFFF_FFFD);
    check("div_lit_hi", bus.HI, 32'hFFFF_FFFF);
    run_op(OP_DIVU, 32'd9, 32'd0, "divu_by0");
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd0, "div_neg_by0");
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, "div_7_neg2");
    run_op(OP_MTLO, 32'd5, 32'd0, "mtlo");
    run_op(OP_MTHI, 32'd0, 32'd0, "mthi");
    run_op(OP_MADD, 32'd2, 32'd3, "madd");
    check("madd_lit_lo", bus.LO, 32'd11);
    run_op(OP_MSUB, 32'd4, 32'd4, "msub");
    check("msub_lit", {bus.HI, bus.LO}, 64'hFFFF_FFFF_FFFF_FFFB);
    run_op(OP_MULT, 32'h1234_5678, 32'd0, "mult_by0");
    run_op(4'hC, 32'hDEAD_BEEF, 32'd1, "undef_op");

    // Flush in RUN: return to IDLE, HI/LO untouched
    run_op(OP_MTHI, 32'hA5A5_0001, 32'd0, "pre_flush");
    bus.Start = 1'b1; bus.Op = OP_MULTU; bus.A = 32'd77; bus.B = 32'hF000_1234;
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (9) @(negedge clk);
    bus.Flush = 1'b1;
    @(negedge clk);
    bus.Flush = 1'b0;
    #1;
    check("flush_run_busy", bus.Busy, 1'b0);
    check("flush_run_done", bus.Done, 1'b0);
    check("flush_run_hi",   bus.HI,   exp_hi);
    check("flush_run_lo",   bus.LO,   exp_lo);
    @(negedge clk);
    #1;
    check("flush_run_done2", bus.Done, 1'b0);

    // Flush coinciding with the final FIX edge: no write
    lat = exp_latency(OP_MULT, 32'h8765_4321);
    bus.Start = 1'b1; bus.Op = OP_MULT; bus.A = 32'h1111_2222; bus.B = 32'h8765_4321;
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (lat - 1) @(negedge clk);
    bus.Flush = 1'b1;
    @(negedge clk);
    bus.Flush = 1'b0;
    #1;
    check("flush_fix_done", bus.Done, 1'b0);
    check("flush_fix_busy", bus.Busy, 1'b0);
    check("flush_fix_hilo", {bus.HI, bus.LO}, {exp_hi, exp_lo});

    // Flush in IDLE blocks acceptance
    bus.Start = 1'b1; bus.Flush = 1'b1; bus.Op = OP_MTLO; bus.A = 32'h0BAD_F00D;
    @(negedge clk);
    bus.Op = OP_DIVU;
    @(negedge clk);
    bus.Start = 1'b0; bus.Flush = 1'b0;
    #1;
    check("flush_idle_lo",   bus.LO,   exp_lo);
    check("flush_idle_busy", bus.Busy, 1'b0);

    // Start while busy: stalled until Done, accepted the following edge
    lat = exp_latency(OP_MULT, 32'h9000_0003);
    bus.Start = 1'b1; bus.Op = OP_MULT; bus.A = 32'h0000_1001; bus.B = 32'h9000_0003;
    @(negedge clk);
    bus.Start = 1'b0;
    ref_exec(OP_MULT, 32'h0000_1001, 32'h9000_0003);
    for (int j = 0; j < lat; j++) begin
      if (j == 5) begin
        bus.Start = 1'b1; bus.Op = OP_DIVU; bus.A = 32'd1000; bus.B = 32'd7;
      end
      #1;
      check("chain_busy",  bus.Busy,  1'b1);
      check("chain_stall", bus.Stall, (j >= 5) ? 1'b1 : 1'b0);
      @(negedge clk);
    end
    #1;
    check("chain_done1",  bus.Done,  1'b1);
    check("chain_stall0", bus.Stall, 1'b0);
    check("chain_hilo1",  {bus.HI, bus.LO}, {exp_hi, exp_lo});
    @(negedge clk);
    bus.Start = 1'b0;
    ref_exec(OP_DIVU, 32'd1000, 32'd7);
    wait_done(exp_latency(OP_DIVU, 32'd7), "chain_op2");

    // Asynchronous reset in the middle of a divide
    bus.Start = 1'b1; bus.Op = OP_DIV; bus.A = 32'h7FFF_0000; bus.B = 32'd3;
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp_hi = '0;
    exp_lo = '0;
    check("arst_busy", bus.Busy, 1'b0);
    check("arst_hilo", {bus.HI, bus.LO}, 64'd0);
    check("arst_done", bus.Done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("arst_after_busy", bus.Busy, 1'b0);

    // Randomized op stream
    for (int n = 0; n < 40; n++) begin
      op = ($urandom_range(0, 9) == 9) ? 4'(8 + $urandom_range(0, 7)) : 4'($urandom_range(0, 7));
      run_op(op, rand_operand(), rand_operand(), $sformatf("rnd%0d_op%0d", n, op));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
